scan_7seg: RTL

- Time-multiplexed driver for N common-cathode 7-segment digits, built on the existing single-digit decoder's segment encoding.
- Adds a parametrised digit count and a scan prescaler.
- Adds a decimal/hex mode, per-digit decimal points, and tear-free double-buffered loading.
- Sits between the CPU's output port register and the board display pins.

---
 rtl/scan_7seg_if.sv | 26 ++
 rtl/scan_7seg.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/scan_7seg_if.sv
// Display-side bundle for the multiplexed 7-segment scanner.
// master = CPU/port side, slave = scan_7seg.
interface scan_7seg_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] data;
    logic [N_DIGITS-1:0]   dp;
    logic                  load;
    logic                  hex;
    logic                  en;
    logic [6:0]            seg;
    logic                  seg_dp;
    logic [N_DIGITS-1:0]   dig;
    logic                  frame;
    logic                  busy;

    modport master (
        output data, dp, load, hex, en,
        input  seg, seg_dp, dig, frame, busy
    );

    modport slave (
        input  data, dp, load, hex, en,
        output seg, seg_dp, dig, frame, busy
    );
endinterface

// File: rtl/scan_7seg.sv
// Time-multiplexed N-digit common-cathode 7-segment driver, double buffered.
// Optional leading-zero blanking: define SCAN_7SEG_LZB_EN.
module scan_7seg #(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    scan_7seg_if.slave  bus
);
    localparam int DW = 4 * N_DIGITS;
    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_DIGITS - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DW-1:0]       disp_q, disp_d;
    logic [N_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [DW-1:0]       pend_q, pend_d;
    logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                busy_q, busy_d;
    logic [6:0]          seg_q, seg_d;
    logic                seg_dp_q, seg_dp_d;
    logic [N_DIGITS-1:0] dig_q, dig_d;
    logic                frame_q, frame_d;

    logic                tick;
    logic                fb;
    logic [3:0]          nib;
    logic [6:0]          glyph;
    logic                blank;

    function automatic logic [6:0] decode(input logic [3:0] v,
                                          input logic       hx);
        logic [6:0] g;
        g = 7'b0000000;
        case (v)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = hx ? 7'b1110111 : 7'b0000000;
            4'hB: g = hx ? 7'b0011111 : 7'b0000000;
            4'hC: g = hx ? 7'b1001110 : 7'b0000000;
            4'hD: g = hx ? 7'b0111101 : 7'b0000000;
            4'hE: g = hx ? 7'b1001111 : 7'b0000000;
            4'hF: g = hx ? 7'b1000111 : 7'b0000000;
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    assign tick  = bus.en && (presc_q == P_LAST);
    assign fb    = tick && (idx_q == I_LAST);
    assign nib   = disp_q[{idx_q, 2'b00} +: 4];
    assign glyph = decode(nib, bus.hex);

`ifdef SCAN_7SEG_LZB_EN
    logic [N_DIGITS-1:0] lead_zero;

    // A digit is blank when it and every digit above it are zero.
    always_comb begin : lzb
        logic nz_above;
        nz_above  = 1'b0;
        lead_zero = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (disp_q[4*i +: 4] != 4'h0) nz_above = 1'b1;
            lead_zero[i] = !nz_above;
        end
    end

    assign blank = lead_zero[idx_q];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        presc_d   = presc_q;
        idx_d     = idx_q;
        disp_d    = disp_q;
        disp_dp_d = disp_dp_q;
        pend_d    = pend_q;
        pend_dp_d = pend_dp_q;
        busy_d    = busy_q;
        seg_d     = 7'b0000000;
        seg_dp_d  = 1'b0;
        dig_d     = '0;
        frame_d   = fb;

        if (!bus.en) begin
            presc_d = '0;
            idx_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            idx_d   = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        // A load landing on the frame boundary bypasses the pending buffer.
        if (bus.load && fb) begin
            disp_d    = bus.data;
            disp_dp_d = bus.dp;
            busy_d    = 1'b0;
        end else if (bus.load) begin
            pend_d    = bus.data;
            pend_dp_d = bus.dp;
            busy_d    = 1'b1;
        end else if (fb && busy_q) begin
            disp_d    = pend_q;
            disp_dp_d = pend_dp_q;
            busy_d    = 1'b0;
        end

        if (bus.en) begin
            dig_d    = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q;
            seg_d    = blank ? 7'b0000000 : glyph;
            seg_dp_d = disp_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q   <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            disp_dp_q <= '0;
            pend_q    <= '0;
            pend_dp_q <= '0;
            busy_q    <= 1'b0;
            seg_q     <= 7'b0000000;
            seg_dp_q  <= 1'b0;
            dig_q     <= '0;
            frame_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            disp_dp_q <= disp_dp_d;
            pend_q    <= pend_d;
            pend_dp_q <= pend_dp_d;
            busy_q    <= busy_d;
            seg_q     <= seg_d;
            seg_dp_q  <= seg_dp_d;
            dig_q     <= dig_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.seg    = seg_q;
    assign bus.seg_dp = seg_dp_q;
    assign bus.dig    = dig_q;
    assign bus.frame  = frame_q;
    assign bus.busy   = busy_q;
endmodule
